// File: rtl/sys_array_tiler_if.sv
// Handshake and data bundle for the systolic-array tiler.
// The master side (testbench or host) drives requests, configuration and
// operand matrices; the slave side (the tiler) returns status and matrix C.
interface sys_array_tiler_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int MAX_K      = 8
);
  logic                                            weights_load;
  logic                                            start_comp;
  logic [7:0]                                      cfg_m;
  logic [7:0]                                      cfg_k;
  logic [7:0]                                      cfg_n;
  logic                                            signed_mode;
  logic                                            acc_mode;
  logic [ARRAY_W-1:0][MAX_K-1:0][DATA_WIDTH-1:0]   input_data;
  logic [MAX_K-1:0][ARRAY_L-1:0][DATA_WIDTH-1:0]   weights;
  logic                                            busy;
  logic                                            ready;
  logic                                            err;
  logic [ARRAY_W-1:0][ARRAY_L-1:0][ACC_WIDTH-1:0]  out_data;

  modport master (
    output weights_load, start_comp, cfg_m, cfg_k, cfg_n,
           signed_mode, acc_mode, input_data, weights,
    input  busy, ready, err, out_data
  );

  modport slave (
    input  weights_load, start_comp, cfg_m, cfg_k, cfg_n,
           signed_mode, acc_mode, input_data, weights,
    output busy, ready, err, out_data
  );
endinterface

// File: rtl/sys_array_tiler.sv
// Output-stationary systolic matrix multiplier C = A*B (or C += A*B).
// Each PE(i,j) owns one accumulator; at step s it consumes the operand pair
// with k = s-i-j, which models the skewed wavefront of a real array.
// The result matrix is published only when the whole wavefront has drained.
module sys_array_tiler #(
  parameter int DATA_WIDTH = 8,
  parameter int ACC_WIDTH  = 2*DATA_WIDTH+4,
  parameter int ARRAY_W    = 4,
  parameter int ARRAY_L    = 4,
  parameter int MAX_K      = 8
) (
  input logic             clk,
  input logic             reset,
  sys_array_tiler_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam logic [7:0] M_LIMIT = 8'(ARRAY_W);
  localparam logic [7:0] N_LIMIT = 8'(ARRAY_L);
  localparam logic [7:0] K_LIMIT = 8'(MAX_K);

  state_t                                          state_r;
  logic [ARRAY_W-1:0][MAX_K-1:0][DATA_WIDTH-1:0]   a_r;
  logic [MAX_K-1:0][ARRAY_L-1:0][DATA_WIDTH-1:0]   b_r;
  logic [7:0]                                      cfg_m_r;
  logic [7:0]                                      cfg_k_r;
  logic [7:0]                                      cfg_n_r;
  logic                                            signed_r;
  logic [9:0]                                      step_r;
  logic [ARRAY_W-1:0][ARRAY_L-1:0][ACC_WIDTH-1:0]  acc_r;
  logic [ARRAY_W-1:0][ARRAY_L-1:0][ACC_WIDTH-1:0]  out_r;
  logic                                            busy_r;
  logic                                            ready_r;
  logic                                            err_r;

  logic                                            cfg_valid_s;
  logic [9:0]                                      last_step_s;
  logic [ARRAY_W-1:0][ARRAY_L-1:0][ACC_WIDTH-1:0]  acc_next_s;
  logic [ARRAY_W-1:0][ARRAY_L-1:0][ACC_WIDTH-1:0]  out_next_s;

  // Extend both operands to the accumulator width before multiplying so the
  // truncated product is already the correctly wrapped contribution.
  function automatic logic [ACC_WIDTH-1:0] pe_product(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b,
    input logic                  sgn
  );
    logic [ACC_WIDTH-1:0] ea;
    logic [ACC_WIDTH-1:0] eb;
    if (sgn) begin
      ea = {{(ACC_WIDTH-DATA_WIDTH){a[DATA_WIDTH-1]}}, a};
      eb = {{(ACC_WIDTH-DATA_WIDTH){b[DATA_WIDTH-1]}}, b};
    end else begin
      ea = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, a};
      eb = {{(ACC_WIDTH-DATA_WIDTH){1'b0}}, b};
    end
    return ea * eb;
  endfunction

  // Configuration check and step count derived from the captured cfg.
  always_comb begin
    cfg_valid_s = (cfg_m_r != 8'd0) && (cfg_k_r != 8'd0) && (cfg_n_r != 8'd0) &&
                  (cfg_m_r <= M_LIMIT) && (cfg_k_r <= K_LIMIT) && (cfg_n_r <= N_LIMIT);
    last_step_s = {2'b00, cfg_m_r} + {2'b00, cfg_n_r} + {2'b00, cfg_k_r} - 10'd2;
  end

  // One wavefront step: each active PE adds the operand pair on its diagonal.
  always_comb begin
    acc_next_s = acc_r;
    for (int i = 0; i < ARRAY_W; i++) begin
      for (int j = 0; j < ARRAY_L; j++) begin
        for (int kk = 0; kk < MAX_K; kk++) begin
          if ((i < int'(cfg_m_r)) && (j < int'(cfg_n_r)) && (kk < int'(cfg_k_r)) &&
              (int'(step_r) == i + j + kk)) begin
            acc_next_s[i][j] = acc_next_s[i][j] + pe_product(a_r[i][kk], b_r[kk][j], signed_r);
          end else begin
            acc_next_s[i][j] = acc_next_s[i][j];
          end
        end
      end
    end
  end

  // Result image: PE values inside the M x N window, zero elsewhere.
  always_comb begin
    out_next_s = '0;
    for (int i = 0; i < ARRAY_W; i++) begin
      for (int j = 0; j < ARRAY_L; j++) begin
        if ((i < int'(cfg_m_r)) && (j < int'(cfg_n_r))) begin
          out_next_s[i][j] = acc_r[i][j];
        end else begin
          out_next_s[i][j] = '0;
        end
      end
    end
  end

  // Control FSM with operand capture, PE accumulation and result publication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r  <= IDLE;
      a_r      <= '0;
      b_r      <= '0;
      cfg_m_r  <= 8'd0;
      cfg_k_r  <= 8'd0;
      cfg_n_r  <= 8'd0;
      signed_r <= 1'b0;
      step_r   <= 10'd0;
      acc_r    <= '0;
      out_r    <= '0;
      busy_r   <= 1'b0;
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE, DONE: begin
          // Weights captured on the same edge as start feed that computation.
          if (bus.weights_load) begin
            b_r <= bus.weights;
          end
          if (bus.start_comp) begin
            a_r      <= bus.input_data;
            cfg_m_r  <= bus.cfg_m;
            cfg_k_r  <= bus.cfg_k;
            cfg_n_r  <= bus.cfg_n;
            signed_r <= bus.signed_mode;
            acc_r    <= bus.acc_mode ? out_r : '0;
            step_r   <= 10'd0;
            ready_r  <= 1'b0;
            err_r    <= 1'b0;
            state_r  <= COMPUTE;
          end
        end
        COMPUTE: begin
          if (!cfg_valid_s) begin
            // Rejected job: report without ever raising busy.
            err_r   <= 1'b1;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end else if (step_r == last_step_s) begin
            out_r   <= out_next_s;
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            state_r <= DONE;
          end else begin
            acc_r  <= acc_next_s;
            step_r <= step_r + 10'd1;
            busy_r <= 1'b1;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy     = busy_r;
  assign bus.ready    = ready_r;
  assign bus.err      = err_r;
  assign bus.out_data = out_r;

endmodule

// File: tb/tb_sys_array_tiler.sv
// Self-checking bench for sys_array_tiler: random operands checked against a
// plain-arithmetic matrix model, plus latency, error and reset scenarios.
module tb_sys_array_tiler;
  localparam int DW = 8;
  localparam int AW = 2*DW+4;
  localparam int W  = 4;
  localparam int L  = 4;
  localparam int MK = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [DW-1:0] drv_a   [W][MK];
  logic [DW-1:0] drv_b   [MK][L];
  logic [DW-1:0] model_b [MK][L];
  logic [AW-1:0] exp_out [W][L];

  sys_array_tiler_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ARRAY_W(W), .ARRAY_L(L), .MAX_K(MK)) bus ();

  sys_array_tiler #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .ARRAY_W(W), .ARRAY_L(L), .MAX_K(MK)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic drive_a(input bit rnd, input logic [DW-1:0] v);
    for (int i = 0; i < W; i++)
      for (int kk = 0; kk < MK; kk++) begin
        drv_a[i][kk] = rnd ? DW'($urandom) : v;
        bus.input_data[i][kk] = drv_a[i][kk];
      end
  endtask

  task automatic drive_b(input bit rnd, input logic [DW-1:0] v);
    for (int kk = 0; kk < MK; kk++)
      for (int j = 0; j < L; j++) begin
        drv_b[kk][j] = rnd ? DW'($urandom) : v;
        bus.weights[kk][j] = drv_b[kk][j];
      end
  endtask

  task automatic pulse_wl();
    bus.weights_load = 1'b1;
    @(posedge clk); #1;
    bus.weights_load = 1'b0;
    model_b = drv_b;
  endtask

  // Leaves the bench at T0+#1.
  task automatic pulse_start(input int m, input int k, input int n, input bit sgn, input bit accm, input bit wl);
    bus.cfg_m = 8'(m); bus.cfg_k = 8'(k); bus.cfg_n = 8'(n);
    bus.signed_mode = sgn; bus.acc_mode = accm;
    bus.start_comp = 1'b1; bus.weights_load = wl;
    @(posedge clk); #1;
    bus.start_comp = 1'b0; bus.weights_load = 1'b0;
    if (wl) model_b = drv_b;
  endtask

  // Reference: C[i][j] = seed + sum_k A[i][k]*B[k][j], wrapped to AW bits.
  task automatic model_compute(input int m, input int k, input int n, input bit sgn, input bit accm);
    logic [AW-1:0] nxt [W][L];
    longint s, x, y;
    if (m < 1 || m > W || k < 1 || k > MK || n < 1 || n > L) return;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < L; j++) begin
        if (i < m && j < n) begin
          s = accm ? longint'(exp_out[i][j]) : 64'sd0;
          for (int kk = 0; kk < k; kk++) begin
            x = sgn ? longint'($signed(drv_a[i][kk])) : longint'(drv_a[i][kk]);
            y = sgn ? longint'($signed(model_b[kk][j])) : longint'(model_b[kk][j]);
            s = s + x * y;
          end
          nxt[i][j] = s[AW-1:0];
        end else begin
          nxt[i][j] = '0;
        end
      end
    exp_out = nxt;
  endtask

  // Waits (bounded) for ready; reports cycles waited, busy cycles seen and
  // whether out_data moved before ready.
  task automatic wait_done(output int lat, output int busy_cnt, output bit moved);
    logic [W-1:0][L-1:0][AW-1:0] snap;
    snap = bus.out_data;
    lat = 0; busy_cnt = 0; moved = 1'b0;
    while (lat < 2000) begin
      @(posedge clk); #1;
      lat++;
      if (bus.busy === 1'b1) busy_cnt++;
      if (bus.ready === 1'b1) break;
      if (bus.out_data !== snap) moved = 1'b1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({bus.busy, bus.ready, bus.err} !== 3'b000) begin
      errors++; $display("FAIL reset_flags: got %b expected 000", {bus.busy, bus.ready, bus.err});
    end
    checks++;
    if (bus.out_data !== '0) begin
      errors++; $display("FAIL reset_out: got %h expected 0", bus.out_data);
    end
    reset = 1'b0;
    for (int i = 0; i < W; i++) for (int j = 0; j < L; j++) exp_out[i][j] = '0;
    for (int kk = 0; kk < MK; kk++) for (int j = 0; j < L; j++) model_b[kk][j] = '0;
  endtask

  task automatic test_basic();
    int lat, bc; bit mv;
    drive_a(1'b1, '0); drive_b(1'b1, '0);
    pulse_wl();
    pulse_start(4, 3, 4, 1'b1, 1'b0, 1'b0);
    model_compute(4, 3, 4, 1'b1, 1'b0);
    checks++;
    if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_t0: got %b expected 0", bus.busy); end
    wait_done(lat, bc, mv);
    checks++;
    if (lat != 10 || bc != 9) begin errors++; $display("FAIL basic_latency: got lat=%0d busy=%0d expected lat=10 busy=9", lat, bc); end
    checks++;
    if (mv || bus.err !== 1'b0) begin errors++; $display("FAIL basic_status: got moved=%0d err=%b expected 0 0", mv, bus.err); end
    for (int i = 0; i < W; i++) for (int j = 0; j < L; j++) begin
      checks++;
      if (bus.out_data[i][j] !== exp_out[i][j]) begin
        errors++; $display("FAIL basic_out[%0d][%0d]: got %h expected %h", i, j, bus.out_data[i][j], exp_out[i][j]);
      end
    end
  endtask

  task automatic test_accumulate();
    int lat, bc; bit mv;
    logic [AW-1:0] prev [W][L];
    prev = exp_out;
    pulse_start(4, 3, 4, 1'b1, 1'b1, 1'b0);
    model_compute(4, 3, 4, 1'b1, 1'b1);
    checks++;
    if (bus.ready !== 1'b0) begin errors++; $display("FAIL acc_ready_clear: got %b expected 0", bus.ready); end
    wait_done(lat, bc, mv);
    checks++;
    if (lat != 10 || bc != 9 || mv) begin errors++; $display("FAIL acc_latency: got lat=%0d busy=%0d moved=%0d expected 10 9 0", lat, bc, mv); end
    for (int i = 0; i < W; i++) for (int j = 0; j < L; j++) begin
      checks++;
      if (bus.out_data[i][j] !== exp_out[i][j] || exp_out[i][j] !== AW'(prev[i][j] * 2)) begin
        errors++; $display("FAIL acc_out[%0d][%0d]: got %h expected %h", i, j, bus.out_data[i][j], AW'(prev[i][j] * 2));
      end
    end
  endtask

  task automatic test_corner();
    int lat, bc; bit mv;
    drive_a(1'b0, 8'hFF); drive_b(1'b0, 8'hFF);
    pulse_wl();
    for (int sm = 1; sm >= 0; sm--) begin
      pulse_start(1, 8, 1, sm[0], 1'b0, 1'b0);
      model_compute(1, 8, 1, sm[0], 1'b0);
      wait_done(lat, bc, mv);
      checks++;
      if (lat != 9 || bc != 8) begin errors++; $display("FAIL corner_latency: got lat=%0d busy=%0d expected 9 8", lat, bc); end
      checks++;
      if (bus.out_data[0][0] !== (sm == 1 ? 20'd8 : 20'd520200)) begin
        errors++; $display("FAIL corner_out00 signed=%0d: got %0d expected %0d", sm, bus.out_data[0][0], (sm == 1 ? 8 : 520200));
      end
      for (int i = 0; i < W; i++) for (int j = 0; j < L; j++) begin
        checks++;
        if (bus.out_data[i][j] !== exp_out[i][j]) begin
          errors++; $display("FAIL corner_out[%0d][%0d]: got %h expected %h", i, j, bus.out_data[i][j], exp_out[i][j]);
        end
      end
    end
  endtask

  task automatic test_invalid();
    int lat, bc; bit mv;
    for (int t = 0; t < 2; t++) begin
      if (t == 0) pulse_start(4, 0, 4, 1'b0, 1'b0, 1'b0);
      else        pulse_start(W+1, 3, 4, 1'b0, 1'b0, 1'b0);
      checks++;
      if ({bus.busy, bus.ready, bus.err} !== 3'b000) begin
        errors++; $display("FAIL invalid%0d_t0: got %b expected 000", t, {bus.busy, bus.ready, bus.err});
      end
      wait_done(lat, bc, mv);
      checks++;
      if (lat != 1 || bc != 0 || bus.err !== 1'b1 || bus.ready !== 1'b1) begin
        errors++; $display("FAIL invalid%0d_status: got lat=%0d busy=%0d err=%b ready=%b expected 1 0 1 1", t, lat, bc, bus.err, bus.ready);
      end
      for (int i = 0; i < W; i++) for (int j = 0; j < L; j++) begin
        checks++;
        if (bus.out_data[i][j] !== exp_out[i][j]) begin
          errors++; $display("FAIL invalid%0d_out[%0d][%0d]: got %h expected %h", t, i, j, bus.out_data[i][j], exp_out[i][j]);
        end
      end
    end
  endtask

  task automatic test_ignore_in_compute();
    int lat, bc; bit mv;
    drive_a(1'b1, '0); drive_b(1'b1, '0);
    pulse_wl();
    pulse_start(3, 5, 2, 1'b0, 1'b0, 1'b0);
    model_compute(3, 5, 2, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive_a(1'b1, '0); drive_b(1'b1, '0);
    bus.cfg_m = 8'd1; bus.cfg_k = 8'd1; bus.cfg_n = 8'd1;
    bus.start_comp = 1'b1; bus.weights_load = 1'b1;
    @(posedge clk); #1;
    bus.start_comp = 1'b0; bus.weights_load = 1'b0;
    wait_done(lat, bc, mv);
    checks++;
    if (lat != 6 || bc != 5 || mv) begin errors++; $display("FAIL ignore_latency: got lat=%0d busy=%0d moved=%0d expected 6 5 0", lat, bc, mv); end
    for (int i = 0; i < W; i++) for (int j = 0; j < L; j++) begin
      checks++;
      if (bus.out_data[i][j] !== exp_out[i][j]) begin
        errors++; $display("FAIL ignore_out[%0d][%0d]: got %h expected %h", i, j, bus.out_data[i][j], exp_out[i][j]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int lat, bc; bit mv;
    drive_a(1'b1, '0); drive_b(1'b1, '0);
    pulse_wl();
    pulse_start(4, 4, 4, 1'b1, 1'b0, 1'b0);
    repeat (4) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.ready, bus.err} !== 3'b000 || bus.out_data !== '0) begin
      errors++; $display("FAIL midreset_outputs: got flags=%b out=%h expected 000 and 0", {bus.busy, bus.ready, bus.err}, bus.out_data);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < W; i++) for (int j = 0; j < L; j++) exp_out[i][j] = '0;
    for (int kk = 0; kk < MK; kk++) for (int j = 0; j < L; j++) model_b[kk][j] = '0;
    drive_a(1'b1, '0); drive_b(1'b1, '0);
    pulse_start(2, 6, 3, 1'b0, 1'b0, 1'b1);
    model_compute(2, 6, 3, 1'b0, 1'b0);
    wait_done(lat, bc, mv);
    checks++;
    if (lat != 10 || bc != 9) begin errors++; $display("FAIL fresh_latency: got lat=%0d busy=%0d expected 10 9", lat, bc); end
    for (int i = 0; i < W; i++) for (int j = 0; j < L; j++) begin
      checks++;
      if (bus.out_data[i][j] !== exp_out[i][j]) begin
        errors++; $display("FAIL fresh_out[%0d][%0d]: got %h expected %h", i, j, bus.out_data[i][j], exp_out[i][j]);
      end
    end
  endtask

  task automatic test_random();
    int lat, bc, m, k, n; bit mv, sgn, accm, wl;
    for (int it = 0; it < 8; it++) begin
      m = $urandom_range(1, W); k = $urandom_range(1, MK); n = $urandom_range(1, L);
      sgn = 1'($urandom); accm = 1'($urandom); wl = 1'($urandom);
      drive_a(1'b1, '0);
      drive_b(1'b1, '0);
      pulse_start(m, k, n, sgn, accm, wl);
      model_compute(m, k, n, sgn, accm);
      wait_done(lat, bc, mv);
      checks++;
      if (lat != m + n + k - 1 || bc != m + n + k - 2 || mv) begin
        errors++; $display("FAIL rand%0d_latency: got lat=%0d busy=%0d moved=%0d expected %0d %0d 0", it, lat, bc, mv, m + n + k - 1, m + n + k - 2);
      end
      for (int i = 0; i < W; i++) for (int j = 0; j < L; j++) begin
        checks++;
        if (bus.out_data[i][j] !== exp_out[i][j]) begin
          errors++; $display("FAIL rand%0d_out[%0d][%0d]: got %h expected %h", it, i, j, bus.out_data[i][j], exp_out[i][j]);
        end
      end
    end
  endtask

  initial begin
    bus.weights_load = 1'b0; bus.start_comp = 1'b0;
    bus.cfg_m = 8'd0; bus.cfg_k = 8'd0; bus.cfg_n = 8'd0;
    bus.signed_mode = 1'b0; bus.acc_mode = 1'b0;
    bus.input_data = '0; bus.weights = '0;
    reset = 1'b1;
    test_reset();
    test_basic();
    test_accumulate();
    test_corner();
    test_invalid();
    test_ignore_in_compute();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
